// File: rtl/mda_pwm_bank.sv
// Avalon-MM PWM/H-bridge bank: shared period counter, shadow/active registers loaded
// at period wrap, dead-time blanking on direction reversal, readback and write watchdog.
module mda_pwm_bank #(
    parameter int NUM_CH     = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int WDT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic [NUM_CH-1:0]     dir_out,
    output logic                  wdt_tripped
);

    localparam logic [ADDR_WIDTH-1:0] PERIOD_ADDR = ADDR_WIDTH'(2 * NUM_CH);
    localparam logic [ADDR_WIDTH-1:0] WDT_ADDR    = ADDR_WIDTH'(2 * NUM_CH + 1);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(2 * NUM_CH + 2);

    logic                 wr_en;
    logic                 rd_en;
    logic [NUM_CH-1:0]    wr_ctrl;
    logic [NUM_CH-1:0]    wr_duty;
    logic                 wr_period;
    logic                 wr_wdt;
    logic                 wr_status;

    logic [NUM_CH-1:0]    en_sh_reg;
    logic [NUM_CH-1:0]    dir_sh_reg;
    logic [NUM_CH-1:0]    en_act_reg;
    logic [NUM_CH-1:0]    dir_act_reg;
    logic [NUM_CH-1:0]    blank_reg;
    logic [NUM_CH-1:0]    pwm_next;
    logic [NUM_CH-1:0]    pwm_reg;
    logic [NUM_CH-1:0]    dir_out_reg;
    logic [CNT_WIDTH-1:0] duty_sh_reg  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_reg [NUM_CH];
    logic [CNT_WIDTH-1:0] period_sh_reg;
    logic [CNT_WIDTH-1:0] period_act_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 wrap;
    logic                 period_live;

    logic [WDT_WIDTH-1:0] wdt_timeout_reg;
    logic [WDT_WIDTH-1:0] wdt_cnt_reg;
    logic [WDT_WIDTH-1:0] wdt_cnt_next;
    logic                 wdt_tripped_reg;
    logic                 wdt_tripped_next;

    logic [31:0]          rd_mux;
    logic [31:0]          readdata_reg;
    logic                 unused_wdata;

    assign wr_en     = chipselect & write;
    assign rd_en     = chipselect & read;
    assign wr_period = wr_en && (addr == PERIOD_ADDR);
    assign wr_wdt    = wr_en && (addr == WDT_ADDR);
    assign wr_status = wr_en && (addr == STATUS_ADDR);

    // Upper write-data bits are don't-care for every register.
    assign unused_wdata = ^writedata;

    // A zero period parks the counter at 0, so every cycle is a wrap.
    assign wrap        = (cnt_reg == period_act_reg);
    assign period_live = (period_act_reg != '0);
    assign cnt_next    = wrap ? '0 : cnt_reg + CNT_WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_ctrl[gi]  = wr_en && (addr == ADDR_WIDTH'(gi));
            assign wr_duty[gi]  = wr_en && (addr == ADDR_WIDTH'(NUM_CH + gi));
            assign pwm_next[gi] = period_live && en_act_reg[gi] &&
                                  (cnt_reg < duty_act_reg[gi]) &&
                                  !blank_reg[gi] && !wdt_tripped_reg;
        end
    endgenerate

    // Any accepted write feeds the watchdog; a WDT_TIMEOUT write reloads with its new value.
    always_comb begin
        wdt_cnt_next     = wdt_cnt_reg;
        wdt_tripped_next = wdt_tripped_reg;
        if (wr_en) begin
            wdt_cnt_next = wr_wdt ? writedata[WDT_WIDTH-1:0] : wdt_timeout_reg;
            if (wr_status && writedata[0]) begin
                wdt_tripped_next = 1'b0;
            end
        end else if (wdt_cnt_reg != '0) begin
            wdt_cnt_next = wdt_cnt_reg - WDT_WIDTH'(1);
            if ((wdt_cnt_reg == WDT_WIDTH'(1)) && (wdt_timeout_reg != '0)) begin
                wdt_tripped_next = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                rd_mux = {30'd0, dir_sh_reg[i], en_sh_reg[i]};
            end
            if (addr == ADDR_WIDTH'(NUM_CH + i)) begin
                rd_mux = 32'(duty_sh_reg[i]);
            end
        end
        if (addr == PERIOD_ADDR) begin
            rd_mux = 32'(period_sh_reg);
        end
        if (addr == WDT_ADDR) begin
            rd_mux = 32'(wdt_timeout_reg);
        end
        if (addr == STATUS_ADDR) begin
            rd_mux = {30'd0, |blank_reg, wdt_tripped_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_sh_reg       <= '0;
            dir_sh_reg      <= '0;
            en_act_reg      <= '0;
            dir_act_reg     <= '0;
            blank_reg       <= '0;
            pwm_reg         <= '0;
            dir_out_reg     <= '0;
            period_sh_reg   <= '0;
            period_act_reg  <= '0;
            cnt_reg         <= '0;
            wdt_timeout_reg <= '0;
            wdt_cnt_reg     <= '0;
            wdt_tripped_reg <= 1'b0;
            readdata_reg    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_reg[i]  <= '0;
                duty_act_reg[i] <= '0;
            end
        end else begin
            // Active side samples the shadow before this cycle's write lands,
            // so a write on the wrap cycle waits for the next wrap.
            if (wrap) begin
                en_act_reg     <= en_sh_reg;
                dir_act_reg    <= dir_sh_reg;
                blank_reg      <= dir_sh_reg ^ dir_act_reg;
                period_act_reg <= period_sh_reg;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_reg[i] <= duty_sh_reg[i];
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ctrl[i]) begin
                    en_sh_reg[i]  <= writedata[0];
                    dir_sh_reg[i] <= writedata[1];
                end
                if (wr_duty[i]) begin
                    duty_sh_reg[i] <= writedata[CNT_WIDTH-1:0];
                end
            end
            if (wr_period) begin
                period_sh_reg <= writedata[CNT_WIDTH-1:0];
            end
            if (wr_wdt) begin
                wdt_timeout_reg <= writedata[WDT_WIDTH-1:0];
            end

            cnt_reg         <= cnt_next;
            pwm_reg         <= pwm_next;
            dir_out_reg     <= dir_act_reg;
            wdt_cnt_reg     <= wdt_cnt_next;
            wdt_tripped_reg <= wdt_tripped_next;
            if (rd_en) begin
                readdata_reg <= rd_mux;
            end
        end
    end

    assign readdata    = readdata_reg;
    assign pwm_out     = pwm_reg;
    assign dir_out     = dir_out_reg;
    assign wdt_tripped = wdt_tripped_reg;

endmodule
